// File: rtl/soc_system_pio_pkg.sv
// Shared register offsets, edge-type codes and CTRL bit positions for the
// capture PIO and its per-channel slice.
package soc_system_pio_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_IRQMASK = 2'd1;
    localparam logic [1:0] REG_EDGECAP = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_SNAP   = 1;

endpackage

// File: rtl/soc_system_pio_capture_if.sv
// Avalon-MM slave bus of the capture PIO: word address, select, write strobe and data.
interface soc_system_pio_capture_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_pio_chan.sv
// One input channel: synchroniser, edge detect, IRQMASK/EDGECAP/CTRL and irq term.
// PIO_SNAPSHOT_EN adds a shadow register that DATA reads return instead of the live value.
module soc_system_pio_chan
    import soc_system_pio_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_raw,
    input  logic              prime_done,
    input  logic              wr_mask,
    input  logic              wr_edgecap,
    input  logic              wr_ctrl,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ctrl_irq_en_wdata,
`ifdef PIO_SNAPSHOT_EN
    input  logic              snap,
`endif
    output logic [DATA_W-1:0] data_rd,
    output logic [DATA_W-1:0] mask_rd,
    output logic [DATA_W-1:0] edgecap_rd,
    output logic              ctrl_irq_en,
    output logic              irq_term
);

    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] sync_d [SYNC_STAGES];
    logic [DATA_W-1:0] dly_q, dly_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] edgecap_q, edgecap_d;
    logic              ctrl_en_q, ctrl_en_d;
    logic [DATA_W-1:0] sync_last;
    logic [DATA_W-1:0] edge_det;

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = in_raw;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        dly_d = sync_last;
    end

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_det = ~sync_last & dly_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_det = sync_last ^ dly_q;
        end else begin
            edge_det = sync_last & ~dly_q;
        end
    end

    always_comb begin
        mask_d    = mask_q;
        edgecap_d = edgecap_q;
        ctrl_en_d = ctrl_en_q;
        if (wr_mask) mask_d = wdata;
        if (wr_ctrl) ctrl_en_d = ctrl_irq_en_wdata;
        if (wr_edgecap) edgecap_d = edgecap_q & ~wdata;
        // Set applied after the W1C clear so a coincident edge is never lost.
        if (prime_done) edgecap_d = edgecap_d | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            dly_q     <= '0;
            mask_q    <= '0;
            edgecap_q <= '0;
            ctrl_en_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            dly_q     <= dly_d;
            mask_q    <= mask_d;
            edgecap_q <= edgecap_d;
            ctrl_en_q <= ctrl_en_d;
        end
    end

`ifdef PIO_SNAPSHOT_EN
    logic [DATA_W-1:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (snap) shadow_d = sync_last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign data_rd = shadow_q;
`else
    assign data_rd = sync_last;
`endif

    assign mask_rd     = mask_q;
    assign edgecap_rd  = edgecap_q;
    assign ctrl_irq_en = ctrl_en_q;
    assign irq_term    = ctrl_en_q & (|(edgecap_q & mask_q));

endmodule

// File: rtl/soc_system_pio_capture.sv
// Multi-channel Avalon-MM input PIO with edge capture and a single level IRQ.
// Optional PIO_SNAPSHOT_EN: CTRL bit1 write latches all channels into shadow registers.
module soc_system_pio_capture
    import soc_system_pio_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    soc_system_pio_capture_if.slave  avs,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    output logic                     irq
);

    localparam int ADDR_W       = $clog2(NUM_CH) + 2;
    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int PCNT_W       = $clog2(PRIME_CYCLES + 1);

    logic [ADDR_W-1:0] addr;
    logic [1:0]        reg_sel;
    logic [31:0]       ch_sel;
    logic [DATA_W-1:0] wdata_ch;
    logic              wr_en;
    logic              unused_wdata;

    assign addr         = avs.address;
    assign reg_sel      = addr[1:0];
    assign ch_sel       = 32'(addr) >> 2;
    assign wdata_ch     = avs.writedata[DATA_W-1:0];
    assign wr_en        = avs.chipselect & ~avs.write_n;
    assign unused_wdata = ^avs.writedata;

    // Edge capture stays off until the synchroniser has flushed its reset zeros.
    logic [PCNT_W-1:0] prime_cnt_q, prime_cnt_d;
    logic              prime_done;

    assign prime_done = (prime_cnt_q == PCNT_W'(PRIME_CYCLES));

    always_comb begin
        prime_cnt_d = prime_cnt_q;
        if (!prime_done) prime_cnt_d = prime_cnt_q + PCNT_W'(1);
    end

    logic [NUM_CH-1:0] wr_mask, wr_edgecap, wr_ctrl;

    always_comb begin
        wr_mask    = '0;
        wr_edgecap = '0;
        wr_ctrl    = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (wr_en && ch_sel == c) begin
                wr_mask[c]    = (reg_sel == REG_IRQMASK);
                wr_edgecap[c] = (reg_sel == REG_EDGECAP);
                wr_ctrl[c]    = (reg_sel == REG_CTRL);
            end
        end
    end

`ifdef PIO_SNAPSHOT_EN
    logic snap;
    assign snap = (|wr_ctrl) & avs.writedata[CTRL_SNAP];
`endif

    logic [DATA_W-1:0] data_rd    [NUM_CH];
    logic [DATA_W-1:0] mask_rd    [NUM_CH];
    logic [DATA_W-1:0] edgecap_rd [NUM_CH];
    logic [NUM_CH-1:0] ctrl_en;
    logic [NUM_CH-1:0] irq_term;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        soc_system_pio_chan #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_TYPE   (EDGE_TYPE)
        ) u_chan (
            .clk               (clk),
            .reset_n           (reset_n),
            .in_raw            (in_port[c*DATA_W +: DATA_W]),
            .prime_done        (prime_done),
            .wr_mask           (wr_mask[c]),
            .wr_edgecap        (wr_edgecap[c]),
            .wr_ctrl           (wr_ctrl[c]),
            .wdata             (wdata_ch),
            .ctrl_irq_en_wdata (avs.writedata[CTRL_IRQ_EN]),
`ifdef PIO_SNAPSHOT_EN
            .snap              (snap),
`endif
            .data_rd           (data_rd[c]),
            .mask_rd           (mask_rd[c]),
            .edgecap_rd        (edgecap_rd[c]),
            .ctrl_irq_en       (ctrl_en[c]),
            .irq_term          (irq_term[c])
        );
    end

    logic [31:0] readdata_q, readdata_d;
    logic        irq_q, irq_d;

    always_comb begin
        readdata_d = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_sel == c) begin
                case (reg_sel)
                    REG_DATA:    readdata_d = 32'(data_rd[c]);
                    REG_IRQMASK: readdata_d = 32'(mask_rd[c]);
                    REG_EDGECAP: readdata_d = 32'(edgecap_rd[c]);
                    default:     readdata_d = {31'b0, ctrl_en[c]};
                endcase
            end
        end
        irq_d = |irq_term;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt_q <= '0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            prime_cnt_q <= prime_cnt_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_soc_system_pio_capture.sv
// Bench for soc_system_pio_capture: a default 2x32 rising-edge instance and a
// 3x8 any-edge instance; honours PIO_SNAPSHOT_EN for DATA expectations.
module tb_soc_system_pio_capture;

    localparam int SYNC = 2;
`ifdef PIO_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [63:0] in0;
    logic [23:0] in1;
    logic        irq0, irq1;

    int checks = 0;
    int errors = 0;

    soc_system_pio_capture_if #(.ADDR_W(3)) bus0 ();
    soc_system_pio_capture_if #(.ADDR_W(4)) bus1 ();

    soc_system_pio_capture #(
        .DATA_W(32), .NUM_CH(2), .SYNC_STAGES(SYNC), .EDGE_TYPE(0)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .avs(bus0), .in_port(in0), .irq(irq0)
    );

    soc_system_pio_capture #(
        .DATA_W(8), .NUM_CH(3), .SYNC_STAGES(SYNC), .EDGE_TYPE(2)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .avs(bus1), .in_port(in1), .irq(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [63:0] in0;
        logic [23:0] in1;
        logic [31:0] e00, e01;
        logic [7:0]  e10, e11, e12;
    } vec_t;
    vec_t vecs[4];

    logic [31:0] shadow0[2];

    function automatic logic [31:0] dexp0(input int ch, input logic [31:0] live);
        return SNAP_EN ? shadow0[ch] : live;
    endfunction

    function automatic logic [31:0] dexp1(input logic [7:0] live);
        return SNAP_EN ? 32'h0 : {24'h0, live};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input bit d, input logic [3:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] got;
        sb_t e;
        sbq.push_back('{nm, exp});
        if (!d) begin
            bus0.address = a[2:0]; bus0.chipselect = 1'b1; bus0.write_n = 1'b1;
        end else begin
            bus1.address = a; bus1.chipselect = 1'b1; bus1.write_n = 1'b1;
        end
        tick(1);
        bus0.chipselect = 1'b0;
        bus1.chipselect = 1'b0;
        got = d ? bus1.readdata : bus0.readdata;
        e = sbq.pop_front();
        check(e.nm, got, e.exp);
    endtask

    task automatic wr(input bit d, input logic [3:0] a, input logic [31:0] data);
        if (!d) begin
            bus0.address = a[2:0]; bus0.writedata = data;
            bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        end else begin
            bus1.address = a; bus1.writedata = data;
            bus1.chipselect = 1'b1; bus1.write_n = 1'b0;
        end
        tick(1);
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] rst_exp0[8];

        vecs[0] = '{64'h1234_5678_9ABC_DEF0, 24'h12_34_56, 32'h9ABC_DEF0, 32'h1234_5678, 8'h56, 8'h34, 8'h12};
        vecs[1] = '{64'hFFFF_0000_0000_FFFF, 24'hFF_00_A5, 32'h0000_FFFF, 32'hFFFF_0000, 8'hA5, 8'h00, 8'hFF};
        vecs[2] = '{64'h8000_0001_7FFF_FFFE, 24'h80_01_7F, 32'h7FFF_FFFE, 32'h8000_0001, 8'h7F, 8'h01, 8'h80};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 24'h00_00_00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 8'h00, 8'h00};
        shadow0[0] = '0;
        shadow0[1] = '0;

        reset_n = 1'b0;
        in0 = '1;
        in1 = '0;
        bus0.address = '0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
        bus1.address = '0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;

        tick(3);
        check("rst_readdata0", bus0.readdata, 32'h0);
        check("rst_irq0", {31'b0, irq0}, 32'h0);
        check("rst_readdata1", bus1.readdata, 32'h0);
        reset_n = 1'b1;
        tick(SYNC + 3);

        rst_exp0 = '{dexp0(0, 32'hFFFF_FFFF), 0, 0, 0, dexp0(1, 32'hFFFF_FFFF), 0, 0, 0};
        for (int a = 0; a < 8; a++) rd(0, 4'(a), rst_exp0[a], $sformatf("rst0_reg%0d", a));
        check("rst_irq0_primed", {31'b0, irq0}, 32'h0);
        for (int a = 0; a < 16; a++) rd(1, 4'(a), 32'h0, $sformatf("rst1_reg%0d", a));

        // live DATA vectors
        for (int v = 0; v < 4; v++) begin
            in0 = vecs[v].in0;
            in1 = vecs[v].in1;
            tick(SYNC);
            rd(0, 4'd0, dexp0(0, vecs[v].e00), $sformatf("data0_ch0_v%0d", v));
            rd(0, 4'd4, dexp0(1, vecs[v].e01), $sformatf("data0_ch1_v%0d", v));
            rd(1, 4'd0, dexp1(vecs[v].e10), $sformatf("data1_ch0_v%0d", v));
            rd(1, 4'd4, dexp1(vecs[v].e11), $sformatf("data1_ch1_v%0d", v));
            rd(1, 4'd8, dexp1(vecs[v].e12), $sformatf("data1_ch2_v%0d", v));
        end
        wr(0, 4'd2, '1); wr(0, 4'd6, '1);
        wr(1, 4'd2, '1); wr(1, 4'd6, '1); wr(1, 4'd10, '1);
        rd(0, 4'd2, 32'h0, "ec0_cleared");

        // rising edge on ch0 bit 3
        wr(0, 4'd1, 32'h0000_00FF);
        wr(0, 4'd3, 32'h1);
        in0[3] = 1'b0;
        tick(4);
        rd(0, 4'd2, 32'h0, "ec0_fall_ignored");
        in0[3] = 1'b1;
        n = 0;
        while (irq0 !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        check("irq_latency", 32'(n), 32'(SYNC + 2));
        rd(0, 4'd2, 32'h8, "ec0_bit3");

        // W1C
        wr(0, 4'd2, 32'h8);
        check("irq_w1c_lag", {31'b0, irq0}, 32'h1);
        tick(1);
        check("irq_w1c_fall", {31'b0, irq0}, 32'h0);
        rd(0, 4'd2, 32'h0, "ec0_w1c");

        // collision: edge detection and W1C of bit 3 in the same cycle
        in0[3] = 1'b0; tick(4);
        in0[3] = 1'b1; tick(4);
        check("irq_pre_collision", {31'b0, irq0}, 32'h1);
        in0[3] = 1'b0; tick(4);
        in0[3] = 1'b1; tick(2);
        wr(0, 4'd2, 32'h8);
        check("irq_collision_lag", {31'b0, irq0}, 32'h1);
        tick(1);
        check("irq_collision", {31'b0, irq0}, 32'h1);
        rd(0, 4'd2, 32'h8, "ec0_collision");
        wr(0, 4'd2, 32'h0);
        rd(0, 4'd2, 32'h8, "ec0_w1c_zero");
        wr(0, 4'd2, '1);
        tick(1);
        check("irq_cleared", {31'b0, irq0}, 32'h0);

        // channel isolation
        in0[32] = 1'b0; tick(4);
        in0[32] = 1'b1; tick(4);
        rd(0, 4'd6, 32'h1, "ec1_bit0");
        check("irq_ch1_masked", {31'b0, irq0}, 32'h0);
        wr(0, 4'd7, 32'h1);
        tick(1);
        check("irq_ch1_ctrl_only", {31'b0, irq0}, 32'h0);
        wr(0, 4'd5, 32'h1);
        check("irq_mask_lag", {31'b0, irq0}, 32'h0);
        tick(1);
        check("irq_ch1_unmasked", {31'b0, irq0}, 32'h1);
        rd(0, 4'd2, 32'h0, "ch0_isolated");
        rd(0, 4'd1, 32'h0000_00FF, "ch0_mask_kept");
        rd(0, 4'd5, 32'h1, "ch1_mask");
        rd(0, 4'd7, 32'h1, "ch1_ctrl");

        // any-edge instance, 8-bit channels
        wr(1, 4'd1, 32'hFFFF_FF81);
        rd(1, 4'd1, 32'h81, "mask_trunc");
        in1[7] = 1'b1; tick(3);
        rd(1, 4'd2, 32'h80, "any_rise");
        wr(1, 4'd2, 32'h80);
        rd(1, 4'd2, 32'h0, "any_w1c");
        in1[7] = 1'b0; tick(3);
        rd(1, 4'd2, 32'h80, "any_fall");
        check("irq1_ctrl_off", {31'b0, irq1}, 32'h0);
        wr(1, 4'd3, 32'h1);
        tick(1);
        check("irq1_ctrl_on", {31'b0, irq1}, 32'h1);

        // channel index 3 does not exist on the 3-channel instance
        wr(1, 4'd13, '1);
        wr(1, 4'd15, '1);
        wr(1, 4'd14, '1);
        in1 = 24'hC3_5A_A5;
        tick(SYNC);
        rd(1, 4'd12, 32'h0, "oor_data");
        rd(1, 4'd13, 32'h0, "oor_mask");
        rd(1, 4'd15, 32'h0, "oor_ctrl");
        rd(1, 4'd5, 32'h0, "ch1_mask_no_alias");
        rd(1, 4'd11, 32'h0, "ch2_ctrl_no_alias");
        rd(1, 4'd8, dexp1(8'hC3), "data1_ch2_live");

        // snapshot
        in0 = {32'h0000_1234, 32'h0000_00A5};
        tick(SYNC + 2);
        wr(0, 4'd3, 32'h3);
        if (SNAP_EN) begin
            shadow0[0] = 32'h0000_00A5;
            shadow0[1] = 32'h0000_1234;
        end
        in0 = {32'h0000_4321, 32'h0000_005A};
        tick(SYNC + 1);
        rd(0, 4'd0, dexp0(0, 32'h0000_005A), "snap_data_ch0");
        rd(0, 4'd4, dexp0(1, 32'h0000_4321), "snap_data_ch1");
        rd(0, 4'd3, 32'h1, "ctrl_bit1_reads0");
        tick(2);
        check("irq_pre_reset", {31'b0, irq0}, 32'h1);

        // asynchronous reset mid-cycle, then prime restart
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_irq", {31'b0, irq0}, 32'h0);
        check("async_rst_readdata", bus0.readdata, 32'h0);
        shadow0[0] = '0;
        shadow0[1] = '0;
        tick(2);
        reset_n = 1'b1;
        tick(SYNC + 3);
        rd(0, 4'd2, 32'h0, "prime_after_reset");
        rd(0, 4'd1, 32'h0, "mask_after_reset");
        rd(0, 4'd3, 32'h0, "ctrl_after_reset");
        rd(0, 4'd0, dexp0(0, 32'h0000_005A), "data_after_reset");
        check("irq_after_reset", {31'b0, irq0}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
